// File: rtl/bcd_mult_seq_pkg.sv
// Shared definitions for the sequential BCD multiplier.
//   BCD_W      width of one packed BCD digit
//   state_t    controller states (exposed on the debug port)
//   bcd_valid  true when a 4-bit digit is a legal BCD value (0..9)
package bcd_mult_seq_pkg;

    localparam int BCD_W = 4;

    // ST_CHK is the single cycle spent on a rejected operand set before the
    // completion pulse, so an error completes one clock after acceptance.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2,
        ST_CHK  = 2'd3
    } state_t;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_mult_seq_if.sv
// Operand/result bus of the sequential BCD multiplier.
//   start      request, sampled only while the controller is idle
//   a, b       packed BCD multiplicand (NDIG digits) and multiplier digit
//   busy       high while digits are being multiplied
//   done       one-cycle completion pulse
//   err        valid with done, held until the next accepted start
//   p          packed BCD product (NDIG+1 digits), held until the next accepted start
//   dbg_state  current controller state
// Handshake: a request is accepted on the first rising edge at which start=1
// while the controller is idle; a/b are captured on that same edge. Exactly one
// done pulse follows each accepted request; requests made while busy or done
// are dropped, not queued.
interface bcd_mult_seq_if #(parameter int NDIG = 4);
    import bcd_mult_seq_pkg::*;

    logic                    start;
    logic [4*NDIG-1:0]       a;
    logic [3:0]              b;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic [4*(NDIG+1)-1:0]   p;
    state_t                  dbg_state;

    modport master (output start, a, b,
                    input  busy, done, err, p, dbg_state);
    modport slave  (input  start, a, b,
                    output busy, done, err, p, dbg_state);

endinterface

// File: rtl/bcd_digit_add.sv
// Adds a BCD digit and an incoming carry digit, returning one BCD digit and a
// decimal carry bit.
//   po     BCD digit (0..9)
//   cin    carry digit (0..9)
//   digit  (po + cin) mod 10
//   cout   1 when po + cin >= 10
module bcd_digit_add (
    input  logic [3:0] po,
    input  logic [3:0] cin,
    output logic [3:0] digit,
    output logic       cout
);

    logic [4:0] s;

    always_comb begin
        s     = {1'b0, po} + {1'b0, cin};
        cout  = (s >= 5'd10);
        digit = cout ? 4'(s - 5'd10) : s[3:0];
    end

endmodule

// File: rtl/ej5.sv
// One-digit BCD multiplier: x1 * x2 -> two BCD digits {tens, ones}.
//   x1, x2  BCD digits (0..9)
//   y       {tens, ones} of the product (0..81)
module ej5 (
    input  logic [3:0] x1,
    input  logic [3:0] x2,
    output logic [7:0] y
);

    logic [7:0] prod;

    always_comb begin
        prod = x1 * x2;
        y    = {4'(prod / 8'd10), 4'(prod % 8'd10)};
    end

endmodule

// File: rtl/bcd_mult_seq.sv
// Multiplies an NDIG-digit packed-BCD number by one BCD digit, one multiplicand
// digit per clock through a single shared digit multiplier, rippling a BCD
// carry between digits.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  operand/result bus (slave side): start, a, b in; busy, done, err, p,
//        dbg_state out
module bcd_mult_seq
    import bcd_mult_seq_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                clk,
    input  logic                rst,
    bcd_mult_seq_if.slave       bus
);

    localparam int             IW   = $clog2(NDIG + 1);
    localparam logic [IW-1:0]  LAST = IW'(NDIG - 1);

    state_t                        state, next_state;
    logic [IW-1:0]                 idx;
    logic [NDIG-1:0][BCD_W-1:0]    a_r;
    logic [BCD_W-1:0]              b_r;
    logic [BCD_W-1:0]              carry;
    logic [NDIG:0][BCD_W-1:0]      p_r;
    logic                          busy_r, done_r, err_r;

    logic                          ops_valid;
    logic [7:0]                    dprod;
    logic [BCD_W-1:0]              sum_digit;
    logic                          sum_cout;
    logic [BCD_W-1:0]              carry_next;

    // Operand check on the live inputs; only meaningful on the accepting edge.
    always_comb begin
        ops_valid = bcd_valid(bus.b);
        for (int i = 0; i < NDIG; i++) begin
            if (!bcd_valid(bus.a[BCD_W*i +: BCD_W])) begin
                ops_valid = 1'b0;
            end
        end
    end

    ej5 u_mul (
        .x1 (a_r[idx]),
        .x2 (b_r),
        .y  (dprod)
    );

    bcd_digit_add u_add (
        .po    (dprod[3:0]),
        .cin   (carry),
        .digit (sum_digit),
        .cout  (sum_cout)
    );

    // Tens digit of x1*x2 is at most 8, plus one decimal carry: fits in 4 bits.
    assign carry_next = dprod[7:4] + {3'b000, sum_cout};

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (bus.start) next_state = ops_valid ? ST_MUL : ST_CHK;
            ST_MUL:  if (idx == LAST) next_state = ST_DONE;
            ST_CHK:  next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Status flags are registered from next_state so they line up with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= next_state;
            busy_r <= (next_state == ST_MUL);
            done_r <= (next_state == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            carry <= '0;
            a_r   <= '0;
            b_r   <= '0;
            p_r   <= '0;
            err_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_r   <= bus.a;
                        b_r   <= bus.b;
                        idx   <= '0;
                        carry <= '0;
                        p_r   <= '0;
                        err_r <= !ops_valid;
                    end
                end
                ST_MUL: begin
                    p_r[idx] <= sum_digit;
                    carry    <= carry_next;
                    if (idx == LAST) begin
                        p_r[NDIG] <= carry_next;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.p         = p_r;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_bcd_mult_seq.sv
// Bench for bcd_mult_seq: an NDIG=4 instance and an NDIG=1 instance share the
// clock and reset. Expected products come from constants or a decimal
// reference model, are queued when a request is driven and popped when done
// is seen.
module tb_bcd_mult_seq;
    import bcd_mult_seq_pkg::*;

    localparam int NDIG = 4;
    localparam int AW   = 4 * NDIG;
    localparam int PW   = 4 * (NDIG + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [PW-1:0] exp_q[$];
    logic [7:0]    exp1_q[$];
    logic          exp_err_q[$];

    bcd_mult_seq_if #(.NDIG(NDIG)) bus ();
    bcd_mult_seq_if #(.NDIG(1))    bus1 ();

    bcd_mult_seq #(.NDIG(NDIG)) dut  (.clk(clk), .rst(rst), .bus(bus));
    bcd_mult_seq #(.NDIG(1))    dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Decimal reference: convert BCD to an integer, multiply, convert back.
    function automatic logic [PW-1:0] ref_p(input logic [AW-1:0] a, input logic [3:0] b);
        int unsigned   av;
        int unsigned   prod;
        logic [PW-1:0] r;
        av = 0;
        r  = '0;
        for (int i = NDIG - 1; i >= 0; i--) av = av * 10 + int'(a[4*i +: 4]);
        prod = av * int'(b);
        for (int i = 0; i < NDIG + 1; i++) begin
            r[4*i +: 4] = 4'(prod % 10);
            prod = prod / 10;
        end
        return r;
    endfunction

    function automatic logic ref_err(input logic [AW-1:0] a, input logic [3:0] b);
        logic e;
        e = (b > 4'd9);
        for (int i = 0; i < NDIG; i++) if (a[4*i +: 4] > 4'd9) e = 1'b1;
        return e;
    endfunction

    // Drive one request to the NDIG=4 instance; returns at the negedge after
    // the accepting edge (edge 0).
    task automatic issue(input logic [AW-1:0] a, input logic [3:0] b,
                         input logic [PW-1:0] ep, input logic ee);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        exp_q.push_back(ep);
        exp_err_q.push_back(ee);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // k = index of the edge after which done was first seen; nbusy = busy samples.
    task automatic wait_done(output int k, output int nbusy);
        k     = 0;
        nbusy = 0;
        if (bus.busy) nbusy++;
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
            if (bus.busy) nbusy++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.p !== '0)            begin n_fail++; $display("FAIL reset_p: got %h expected 0", bus.p); end
        n_cmp++; if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_cmp++; if (bus.err !== 1'b0)        begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        n_cmp++; if (bus.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.dbg_state); end
        n_cmp++; if (bus1.p !== '0)           begin n_fail++; $display("FAIL reset1_p: got %h expected 0", bus1.p); end
        n_cmp++; if (bus1.busy !== 1'b0)      begin n_fail++; $display("FAIL reset1_busy: got %b expected 0", bus1.busy); end
        n_cmp++; if (bus1.done !== 1'b0)      begin n_fail++; $display("FAIL reset1_done: got %b expected 0", bus1.done); end
        rst = 1'b0;
    endtask

    task automatic test_spec_vectors();
        logic [AW-1:0] va[6] = '{16'h1234, 16'h9999, 16'h0000, 16'h1234, 16'h0909, 16'h5000};
        logic [3:0]    vb[6] = '{4'd5, 4'd9, 4'd7, 4'd0, 4'd9, 4'd2};
        logic [PW-1:0] vp[6] = '{20'h06170, 20'h89991, 20'h00000, 20'h00000, 20'h08181, 20'h10000};
        logic [PW-1:0] ep;
        logic          ee;
        int            k, nb;
        for (int i = 0; i < 6; i++) begin
            issue(va[i], vb[i], vp[i], 1'b0);
            wait_done(k, nb);
            ep = exp_q.pop_front();
            ee = exp_err_q.pop_front();
            n_cmp++; if (k !== NDIG)    begin n_fail++; $display("FAIL vec%0d_latency: got %0d expected %0d", i, k, NDIG); end
            n_cmp++; if (nb !== NDIG)   begin n_fail++; $display("FAIL vec%0d_busy_cycles: got %0d expected %0d", i, nb, NDIG); end
            n_cmp++; if (bus.p !== ep)  begin n_fail++; $display("FAIL vec%0d_p: got %h expected %h", i, bus.p, ep); end
            n_cmp++; if (bus.err !== ee) begin n_fail++; $display("FAIL vec%0d_err: got %b expected %b", i, bus.err, ee); end
            @(negedge clk);
            n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL vec%0d_done_width: got %b expected 0", i, bus.done); end
            repeat (2) @(negedge clk);
            n_cmp++; if (bus.p !== ep)  begin n_fail++; $display("FAIL vec%0d_p_hold: got %h expected %h", i, bus.p, ep); end
        end
    endtask

    task automatic test_error();
        logic [AW-1:0] va[3] = '{16'h12A4, 16'h1234, 16'hF000};
        logic [3:0]    vb[3] = '{4'd3, 4'hA, 4'd0};
        logic [PW-1:0] ep;
        logic          ee;
        int            k, nb;
        for (int i = 0; i < 3; i++) begin
            issue(va[i], vb[i], '0, 1'b1);
            wait_done(k, nb);
            ep = exp_q.pop_front();
            ee = exp_err_q.pop_front();
            n_cmp++; if (k !== 1)        begin n_fail++; $display("FAIL err%0d_latency: got %0d expected 1", i, k); end
            n_cmp++; if (nb !== 0)       begin n_fail++; $display("FAIL err%0d_busy_cycles: got %0d expected 0", i, nb); end
            n_cmp++; if (bus.p !== ep)   begin n_fail++; $display("FAIL err%0d_p: got %h expected %h", i, bus.p, ep); end
            n_cmp++; if (bus.err !== ee) begin n_fail++; $display("FAIL err%0d_err: got %b expected %b", i, bus.err, ee); end
            repeat (3) @(negedge clk);
            n_cmp++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err%0d_err_hold: got %b expected 1", i, bus.err); end
        end
        issue(16'h0002, 4'd3, 20'h00006, 1'b0);
        wait_done(k, nb);
        ep = exp_q.pop_front();
        ee = exp_err_q.pop_front();
        n_cmp++; if (bus.p !== ep)   begin n_fail++; $display("FAIL err_recover_p: got %h expected %h", bus.p, ep); end
        n_cmp++; if (bus.err !== ee) begin n_fail++; $display("FAIL err_recover_err: got %b expected %b", bus.err, ee); end
    endtask

    // start held for edges 0..9: accepted at edge 0 and again at edge NDIG+2.
    task automatic test_start_held();
        logic [PW-1:0] ep;
        logic          ee;
        int            ndone;
        int            at[2];
        ndone = 0;
        at[0] = -1;
        at[1] = -1;
        @(negedge clk);
        bus.a     = 16'h0001;
        bus.b     = 4'd2;
        bus.start = 1'b1;
        repeat (2) begin exp_q.push_back(20'h00002); exp_err_q.push_back(1'b0); end
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            if (j == 1) begin bus.a = 16'h9999; bus.b = 4'd9; end
            if (j == 3) begin bus.a = 16'h0001; bus.b = 4'd2; end
            if (j == 9) bus.start = 1'b0;
            if (bus.done) begin
                if (ndone < 2) at[ndone] = j;
                ndone++;
                if (exp_q.size() > 0) begin
                    ep = exp_q.pop_front();
                    ee = exp_err_q.pop_front();
                    n_cmp++; if (bus.p !== ep)   begin n_fail++; $display("FAIL held_p: got %h expected %h", bus.p, ep); end
                    n_cmp++; if (bus.err !== ee) begin n_fail++; $display("FAIL held_err: got %b expected %b", bus.err, ee); end
                end
            end
        end
        n_cmp++; if (ndone !== 2)         begin n_fail++; $display("FAIL held_op_count: got %0d expected 2", ndone); end
        n_cmp++; if (at[0] !== NDIG)      begin n_fail++; $display("FAIL held_first_done: got %0d expected %0d", at[0], NDIG); end
        n_cmp++; if (at[1] !== 2*NDIG+2)  begin n_fail++; $display("FAIL held_second_done: got %0d expected %0d", at[1], 2*NDIG+2); end
    endtask

    task automatic test_abort();
        logic [PW-1:0] ep;
        logic          ee;
        logic          seen;
        int            k, nb;
        @(negedge clk);
        bus.a     = 16'h4321;
        bus.b     = 4'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b expected 1", bus.busy); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.busy !== 1'b0)        begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.p !== '0)             begin n_fail++; $display("FAIL abort_p: got %h expected 0", bus.p); end
        n_cmp++; if (bus.done !== 1'b0)        begin n_fail++; $display("FAIL abort_done: got %b expected 0", bus.done); end
        n_cmp++; if (bus.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL abort_state: got %0d expected 0", bus.dbg_state); end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b expected 0", seen); end
        issue(16'h4321, 4'd7, 20'h30247, 1'b0);
        wait_done(k, nb);
        ep = exp_q.pop_front();
        ee = exp_err_q.pop_front();
        n_cmp++; if (bus.p !== ep)   begin n_fail++; $display("FAIL abort_next_p: got %h expected %h", bus.p, ep); end
        n_cmp++; if (bus.err !== ee) begin n_fail++; $display("FAIL abort_next_err: got %b expected %b", bus.err, ee); end
    endtask

    // Every 4-bit a and b on the single-digit instance, legal or not.
    task automatic test_exhaustive_ndig1();
        logic [7:0] ep;
        logic       ee;
        int         prod, k;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                prod = a * b;
                @(negedge clk);
                bus1.a     = 4'(a);
                bus1.b     = 4'(b);
                bus1.start = 1'b1;
                if (a <= 9 && b <= 9) begin
                    exp1_q.push_back({4'(prod / 10), 4'(prod % 10)});
                    exp_err_q.push_back(1'b0);
                end else begin
                    exp1_q.push_back(8'h00);
                    exp_err_q.push_back(1'b1);
                end
                @(negedge clk);
                bus1.start = 1'b0;
                k = 0;
                while (!bus1.done && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                ep = exp1_q.pop_front();
                ee = exp_err_q.pop_front();
                n_cmp++; if (k !== 1)         begin n_fail++; $display("FAIL n1_latency a=%0d b=%0d: got %0d expected 1", a, b, k); end
                n_cmp++; if (bus1.p !== ep)   begin n_fail++; $display("FAIL n1_p a=%0d b=%0d: got %h expected %h", a, b, bus1.p, ep); end
                n_cmp++; if (bus1.err !== ee) begin n_fail++; $display("FAIL n1_err a=%0d b=%0d: got %b expected %b", a, b, bus1.err, ee); end
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [3:0]    b;
        logic [PW-1:0] ep;
        logic          ee;
        int            k, nb, exp_k;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NDIG; i++) a[4*i +: 4] = 4'($urandom_range(0, 9));
            b = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) a[4*$urandom_range(0, NDIG-1) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 15) == 0) b = 4'($urandom_range(10, 15));
            ee    = ref_err(a, b);
            exp_k = ee ? 1 : NDIG;
            issue(a, b, ee ? '0 : ref_p(a, b), ee);
            wait_done(k, nb);
            ep = exp_q.pop_front();
            ee = exp_err_q.pop_front();
            n_cmp++; if (k !== exp_k)    begin n_fail++; $display("FAIL rnd_latency a=%h b=%h: got %0d expected %0d", a, b, k, exp_k); end
            n_cmp++; if (bus.p !== ep)   begin n_fail++; $display("FAIL rnd_p a=%h b=%h: got %h expected %h", a, b, bus.p, ep); end
            n_cmp++; if (bus.err !== ee) begin n_fail++; $display("FAIL rnd_err a=%h b=%h: got %b expected %b", a, b, bus.err, ee); end
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
        test_reset();
        test_spec_vectors();
        test_error();
        test_start_held();
        test_abort();
        test_exhaustive_ndig1();
        test_random();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (exp_q.size() + exp1_q.size() + exp_err_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d entries left expected 0",
                     exp_q.size() + exp1_q.size() + exp_err_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
